// File: rtl/ram_ctrl_pkg.sv
// Shared types for the RAM request controller: default widths, FSM states
// and the request record held in the request FIFO.
package ram_ctrl_pkg;

  localparam int unsigned ADDR_W_DEF = 4;
  localparam int unsigned DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    RESP
  } state_t;

  typedef struct packed {
    logic                  write;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] wdata;
  } req_t;

endpackage

// File: rtl/ram_req_fifo.sv
// Circular synchronous FIFO of request records with wrap-bit pointers,
// asynchronous active-low reset on the pointers.
module ram_req_fifo
  import ram_ctrl_pkg::*;
#(
  parameter type         entry_t = req_t,
  parameter int unsigned DEPTH   = 4
) (
  input  logic                   Clock,
  input  logic                   Resetn,
  input  logic                   push,
  input  logic                   pop,
  input  entry_t                 wr_data,
  output entry_t                 rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  entry_t      mem [DEPTH];
  logic [PW:0] wr_ptr;
  logic [PW:0] rd_ptr;

  // Pointers carry one extra bit so full and empty stay distinguishable.
  assign count   = wr_ptr - rd_ptr;
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr[PW-1:0]];

  always_ff @(posedge Clock) begin
    if (push && !full) begin
      mem[wr_ptr[PW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop && !empty) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ram_req_ctrl.sv
// Request-side controller for the 16x32 single-port RAM: queues requests,
// issues them one at a time and returns read data. Optional write acks via
// the RAM_REQ_CTRL_WRITE_ACK_EN macro.
module ram_req_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_is_write,
  output logic              ram_enable,
  output logic              ram_write_en,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data_in,
  input  logic [DATA_W-1:0] ram_data_out,
  input  logic              ram_valid_out,
  output logic              busy,
  output logic              err
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  // Local record sized by this instance's widths rather than package defaults.
  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } ctrl_req_t;

  ctrl_req_t   push_req;
  ctrl_req_t   head;
  logic        push;
  logic        pop;
  logic        fifo_full;
  logic        fifo_empty;
  logic [CW-1:0] fifo_count;
  state_t      state;

  assign push_req  = '{write: req_write, addr: req_addr, wdata: req_wdata};
  assign req_ready = !fifo_full;
  assign push      = req_valid && req_ready;
  assign pop       = (state == IDLE) && !fifo_empty;
  assign busy      = (fifo_count != '0) || (state != IDLE);

  ram_req_fifo #(
    .entry_t (ctrl_req_t),
    .DEPTH   (FIFO_DEPTH)
  ) u_fifo (
    .Clock   (Clock),
    .Resetn  (Resetn),
    .push    (push),
    .pop     (pop),
    .wr_data (push_req),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

`ifndef RAM_REQ_CTRL_WRITE_ACK_EN
  assign rsp_is_write = 1'b0;
`endif

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state        <= IDLE;
      ram_enable   <= 1'b0;
      ram_write_en <= 1'b0;
      ram_address  <= '0;
      ram_data_in  <= '0;
      rsp_valid    <= 1'b0;
      rsp_addr     <= '0;
      rsp_rdata    <= '0;
      err          <= 1'b0;
`ifdef RAM_REQ_CTRL_WRITE_ACK_EN
      rsp_is_write <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            ram_enable   <= 1'b1;
            ram_write_en <= head.write;
            ram_address  <= head.addr;
            ram_data_in  <= head.wdata;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          ram_enable <= 1'b0;
          if (!ram_write_en) begin
            state <= CAPTURE;
          end else begin
`ifdef RAM_REQ_CTRL_WRITE_ACK_EN
            rsp_valid    <= 1'b1;
            rsp_is_write <= 1'b1;
            rsp_addr     <= ram_address;
            rsp_rdata    <= '0;
            state        <= RESP;
`else
            state <= IDLE;
`endif
          end
        end
        CAPTURE: begin
          rsp_rdata <= ram_data_out;
          rsp_addr  <= ram_address;
          rsp_valid <= 1'b1;
`ifdef RAM_REQ_CTRL_WRITE_ACK_EN
          rsp_is_write <= 1'b0;
`endif
          if (!ram_valid_out) begin
            err <= 1'b1;
          end
          state <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_req_ctrl.sv
// Self-checking bench for ram_req_ctrl: behavioural RAM, queue-based
// reference model, directed latency/backpressure/reset/err cases and random traffic.
module tb_ram_req_ctrl;

  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic          Clock = 1'b0;
  logic          Resetn = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [AW-1:0] rsp_addr;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_is_write;
  logic          ram_enable;
  logic          ram_write_en;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_data_in;
  logic [DW-1:0] ram_data_out;
  logic          ram_valid_out;
  logic          busy;
  logic          err;

  always #5 Clock = ~Clock;

  ram_req_ctrl #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .Clock         (Clock),
    .Resetn        (Resetn),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_write     (req_write),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_addr      (rsp_addr),
    .rsp_rdata     (rsp_rdata),
    .rsp_is_write  (rsp_is_write),
    .ram_enable    (ram_enable),
    .ram_write_en  (ram_write_en),
    .ram_address   (ram_address),
    .ram_data_in   (ram_data_in),
    .ram_data_out  (ram_data_out),
    .ram_valid_out (ram_valid_out),
    .busy          (busy),
    .err           (err)
  );

  // Behavioural 16x32 RAM with registered read data and valid.
  logic [DW-1:0] ram_mem [16];
  logic [DW-1:0] ram_dout = '0;
  logic          ram_vout = 1'b0;
  logic          force_invalid = 1'b0;

  initial for (int i = 0; i < 16; i++) ram_mem[i] = '0;

  always @(posedge Clock) begin
    if (ram_enable) begin
      if (ram_write_en) ram_mem[ram_address] <= ram_data_in;
      else              ram_dout <= ram_mem[ram_address];
    end
    ram_vout <= ram_enable && !ram_write_en;
  end

  assign ram_data_out  = ram_dout;
  assign ram_valid_out = ram_vout && !force_invalid;

  // Reference model: memory updated in acceptance order, plus queues of
  // expected RAM issues and expected responses.
  typedef struct {
    bit          w;
    bit [AW-1:0] a;
    bit [DW-1:0] d;
  } item_t;

  logic [DW-1:0] model_mem [16];
  item_t issue_q[$];
  item_t rsp_q[$];
  int    checks = 0;
  int    errors = 0;
  bit    prev_en = 0;
  bit    holding = 0;
  logic [AW+DW:0] held_val;
  bit    rand_rdy = 0;

  initial for (int i = 0; i < 16; i++) model_mem[i] = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge Clock) begin
    if (!Resetn) begin
      issue_q.delete();
      rsp_q.delete();
      prev_en = 0;
      holding = 0;
    end else begin
      if (rsp_valid) begin
        if (holding) check("rsp_stable", 64'({rsp_is_write, rsp_addr, rsp_rdata}), 64'(held_val));
        if (rsp_ready) begin
          if (rsp_q.size() == 0) check("unexpected_rsp", 1, 0);
          else begin
            item_t e;
            e = rsp_q.pop_front();
            check("rsp_addr", 64'(rsp_addr), 64'(e.a));
            check("rsp_rdata", 64'(rsp_rdata), 64'(e.d));
            check("rsp_is_write", 64'(rsp_is_write), 64'(e.w));
          end
          holding = 0;
        end else begin
          holding  = 1;
          held_val = {rsp_is_write, rsp_addr, rsp_rdata};
        end
      end else begin
        holding = 0;
      end

      if (ram_enable) begin
        check("ram_enable_pulse", 64'(prev_en), 0);
        if (issue_q.size() == 0) check("unexpected_issue", 1, 0);
        else begin
          item_t e;
          e = issue_q.pop_front();
          check("ram_write_en", 64'(ram_write_en), 64'(e.w));
          check("ram_address", 64'(ram_address), 64'(e.a));
          if (e.w) check("ram_data_in", 64'(ram_data_in), 64'(e.d));
        end
      end
      prev_en = ram_enable;

      if (rsp_q.size() != 0 || issue_q.size() != 0) check("busy_pending", 64'(busy), 1);

      if (req_valid && req_ready) begin
        item_t it;
        it.w = req_write;
        it.a = req_addr;
        it.d = req_write ? req_wdata : '0;
        issue_q.push_back(it);
        if (req_write) begin
          model_mem[req_addr] = req_wdata;
`ifdef RAM_REQ_CTRL_WRITE_ACK_EN
          it.d = '0;
          rsp_q.push_back(it);
`endif
        end else begin
          it.d = model_mem[req_addr];
          rsp_q.push_back(it);
        end
      end
    end
  end

  always @(posedge Clock) begin
    if (rand_rdy) begin
      #1 rsp_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic send(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit acc;
    int n;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    acc = 0;
    n   = 0;
    while (!acc) begin
      @(negedge Clock);
      acc = req_ready;
      tick();
      n++;
      if (!acc && n > 200) begin
        check("req_accept_timeout", 0, 1);
        acc = 1;
      end
    end
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    @(negedge Clock);
    while ((rsp_q.size() != 0 || issue_q.size() != 0 || busy) && n < 500) begin
      @(negedge Clock);
      n++;
    end
    if (n >= 500) check("drain_timeout", 0, 1);
    check("busy_idle", 64'(busy), 0);
    tick();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rsp"}, 64'({rsp_valid, rsp_is_write, rsp_addr, rsp_rdata}), 0);
    check({tag, "_ram"}, 64'({ram_enable, ram_write_en, ram_address, ram_data_in}), 0);
    check({tag, "_flags"}, 64'({req_ready, busy, err}), 64'b100);
  endtask

  task automatic lat_read(input logic [AW-1:0] a, input logic [DW-1:0] expd);
    send(0, a, '0);
    for (int i = 1; i <= 4; i++) begin
      @(negedge Clock);
      if (i == 2) check("lat_rd_enable", 64'(ram_enable), 1);
      check("lat_rd_rsp_valid", 64'(rsp_valid), 64'(i == 4));
      if (i == 4) begin
        check("lat_rd_addr", 64'(rsp_addr), 64'(a));
        check("lat_rd_data", 64'(rsp_rdata), 64'(expd));
      end
    end
    tick();
  endtask

  task automatic lat_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    send(1, a, d);
    for (int i = 1; i <= 3; i++) begin
      @(negedge Clock);
      if (i == 2) check("lat_wr_enable", 64'({ram_enable, ram_write_en}), 64'b11);
`ifdef RAM_REQ_CTRL_WRITE_ACK_EN
      check("lat_wr_ack_valid", 64'(rsp_valid), 64'(i == 3));
      if (i == 3) check("lat_wr_ack", 64'({rsp_is_write, rsp_addr}), 64'({1'b1, a}));
`else
      check("lat_wr_no_rsp", 64'(rsp_valid), 0);
`endif
    end
    tick();
  endtask

  initial begin
    repeat (3) tick();
    @(negedge Clock);
    check_reset_vals("reset");
    tick();
    Resetn = 1'b1;
    tick();

    lat_read(4'd9, 32'h0);
    drain();
    lat_write(4'd3, 32'hDEADBEEF);
    drain();
    lat_read(4'd3, 32'hDEADBEEF);
    drain();
    check("err_clear", 64'(err), 0);

    // Stall the response and fill the FIFO behind it.
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(0, 4'(i), '0);
    @(negedge Clock);
    check("full_req_ready", 64'(req_ready), 0);
    check("full_busy", 64'(busy), 1);
    tick();
    fork
      send(0, 4'd5, '0);
      begin
        repeat (6) tick();
        rsp_ready = 1'b1;
      end
    join
    drain();

    for (int a = 0; a < 16; a++) send(1, 4'(a), 32'(a) * 32'h11111111);
    for (int a = 0; a < 16; a++) send(0, 4'(a), '0);
    drain();
    check("model_pin_mem15", 64'(model_mem[15]), 64'hFFFFFFFF);

    // Reset while the first of three reads is in CAPTURE.
    send(0, 4'd1, '0);
    send(0, 4'd2, '0);
    send(0, 4'd4, '0);
    Resetn = 1'b0;
    #1;
    check_reset_vals("mid_reset");
    tick();
    Resetn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clock);
      check("post_reset_quiet", 64'({rsp_valid, ram_enable, busy}), 0);
    end
    tick();

    force_invalid = 1'b1;
    send(0, 4'd3, '0);
    drain();
    force_invalid = 1'b0;
    check("err_set", 64'(err), 1);
    send(1, 4'd7, 32'h00C0FFEE);
    send(0, 4'd7, '0);
    drain();
    check("err_sticky", 64'(err), 1);
    Resetn = 1'b0;
    tick();
    check("err_reset", 64'(err), 0);
    Resetn = 1'b1;
    tick();

    rand_rdy = 1;
    for (int i = 0; i < 300; i++) begin
      send(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom);
      repeat ($urandom_range(0, 2)) tick();
    end
    rand_rdy = 0;
    tick();
    rsp_ready = 1'b1;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_req_ctrl.md
Name: ram_req_ctrl

Overview:
Request-side controller that sits directly upstream of the 16x32 single-port RAM and owns its Enable/Write_en/Address/Data_in pins. It accepts read/write requests over a valid/ready handshake, buffers them in a small FIFO, and issues them to the RAM one at a time. For reads it captures the RAM's registered Data_out/Valid_out and returns a response over a second valid/ready handshake.

Parameters:
ADDR_W, 4, RAM address width (RAM depth = 2**ADDR_W)
DATA_W, 32, data width
FIFO_DEPTH, 4, request FIFO entries; power of two, >= 2

Ports:
Clock  in  1  clock; all logic is rising-edge
Resetn  in  1  asynchronous, active-low reset
req_valid  in  1  request offered
req_ready  out  1  FIFO not full
req_write  in  1  1 = write, 0 = read
req_addr  in  ADDR_W  request address
req_wdata  in  DATA_W  write data; ignored for reads
rsp_valid  out  1  response held
rsp_ready  in  1  consumer accepts response
rsp_addr  out  ADDR_W  address of the response
rsp_rdata  out  DATA_W  read data
rsp_is_write  out  1  response is a write ack (WRITE_ACK_EN only; otherwise tied 0)
ram_enable  out  1  to RAM Enable
ram_write_en  out  1  to RAM Write_en
ram_address  out  ADDR_W  to RAM Address
ram_data_in  out  DATA_W  to RAM Data_in
ram_data_out  in  DATA_W  from RAM Data_out
ram_valid_out  in  1  from RAM Valid_out
busy  out  1  FIFO non-empty or FSM not in IDLE
err  out  1  sticky: read captured with ram_valid_out=0

Behaviour:
- Reset: all outputs are 0 except req_ready=1. FIFO is emptied and the FSM goes to IDLE. Reset mid-transaction drops any in-flight or queued request with no response.
- Accept: a request is taken on any edge where req_valid && req_ready. req_ready = !full, combinational from the FIFO count.
- Simultaneous push and pop while full is not allowed: req_ready is low when full.
- All ram_* outputs are registered. ram_enable is high for exactly one cycle per request.
- FSM states: IDLE, ISSUE, CAPTURE, RESP.
- IDLE: if the FIFO is non-empty, pop the head, load ram_address/ram_write_en/ram_data_in, set ram_enable<=1, go to ISSUE.
- ISSUE: ram_enable<=0. Read goes to CAPTURE. Write goes to IDLE, or to RESP with WRITE_ACK_EN.
- CAPTURE: rsp_rdata<=ram_data_out, rsp_addr<=ram_address, rsp_valid<=1, go to RESP. If ram_valid_out==0 here, set err (cleared only by reset).
- RESP: hold rsp_valid and the payload stable until rsp_ready. On the accepting edge, rsp_valid<=0 and go to IDLE. No new RAM access is issued while in RESP (backpressure stalls the RAM).
- Latency, empty FIFO, FSM in IDLE, request accepted at edge 0:
  - ram_enable is high in cycle 2.
  - read rsp_valid is first high in cycle 4.
  - write throughput is 1 per 2 cycles; read throughput is 1 per 4 cycles with rsp_ready held high.
- Ordering: strict FIFO order, so read-after-write to the same address returns the new data.
- FIFO: circular, log2(FIFO_DEPTH)+1-bit pointers, wrap-around at FIFO_DEPTH. Full when count==FIFO_DEPTH; empty when count==0.
- A push to an empty FIFO is visible to IDLE on the next cycle (no bypass).

Optional Feature:
Macro RAM_REQ_CTRL_WRITE_ACK_EN.
- Defined: writes also produce a response after ISSUE with rsp_is_write=1, rsp_addr=write address and rsp_rdata=0, with the same RESP handshake. Write latency to rsp_valid is 3 cycles.
- Undefined: writes complete silently, rsp_is_write is tied 0, and the FSM never enters RESP for a write.

Decomposition:
- Package ram_ctrl_pkg holds:
  - ADDR_W/DATA_W defaults
  - the state enum typedef (IDLE, ISSUE, CAPTURE, RESP)
  - a packed request struct typedef {write, addr, wdata}
- One sub-module, ram_req_fifo: parameterised synchronous FIFO of the request struct, with push/pop/full/empty/count and async active-low reset.

Test Plan:
- Reset, then write addr 3 data 0xDEADBEEF, then read addr 3 with rsp_ready=1 -> rsp_valid is high exactly 4 cycles after the read is accepted, rsp_addr=3, rsp_rdata=0xDEADBEEF, err=0.
- Hold rsp_ready=0 and push 6 requests (FIFO_DEPTH=4) -> req_ready drops once 4 requests are queued behind the stalled one; nothing is lost; on release, responses come back in order.
- Back-to-back writes to addr 0..15 with data = addr*0x11111111, then read all 16 -> every rsp_rdata matches, pointers wrap cleanly, busy falls after the last response.
- Read of a never-written addr 9 after reset -> rsp_rdata=0.
- Assert Resetn low in CAPTURE with 2 requests queued -> all outputs return to reset values, req_ready=1, no rsp_valid after release.
- Force ram_valid_out=0 during CAPTURE -> err=1 and stays 1 until reset.
- With RAM_REQ_CTRL_WRITE_ACK_EN defined: write addr 5 -> rsp_valid with rsp_is_write=1, rsp_addr=5, 3 cycles after accept.
